// File: rtl/axi_defines.sv
// axi_defines: AXI4-lite bus widths and response codes shared by fabric initiators and slaves.
package axi_defines;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp == AXI_RESP_SLVERR || resp == AXI_RESP_DECERR;
  endfunction
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-lite initiator bridging the core load/store request port.
module axi_lite_master
  import axi_defines::*;
#(
  parameter int ADDR_W = AXI_ADDR_WIDTH,
  parameter int DATA_W = AXI_DATA_WIDTH,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_strb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
  state_t state, state_nx;
  logic aw_nx, w_nx, b_nx, ar_nx, r_nx, rv_nx, err_nx;
  logic [ADDR_W-1:0] awaddr_nx, araddr_nx;
  logic [DATA_W-1:0] wdata_nx, rdata_nx;
  logic [STRB_W-1:0] wstrb_nx;
  assign req_ready = state == IDLE;
  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;
  always_comb begin
    state_nx = state;
    aw_nx = AWVALID;
    w_nx = WVALID;
    b_nx = BREADY;
    ar_nx = ARVALID;
    r_nx = RREADY;
    awaddr_nx = AWADDR;
    araddr_nx = ARADDR;
    wdata_nx = WDATA;
    wstrb_nx = WSTRB;
    rv_nx = 1'b0;
    rdata_nx = resp_rdata;
    err_nx = resp_err;
    case (state)
      IDLE: if (req_valid) begin
        wdata_nx = req_wdata;
        wstrb_nx = req_strb;
        if (req_write) begin
          awaddr_nx = req_addr;
          aw_nx = 1'b1;
          w_nx = 1'b1;
          state_nx = WR_REQ;
        end else begin
          araddr_nx = req_addr;
          ar_nx = 1'b1;
          state_nx = RD_REQ;
        end
      end
      // AW and W retire independently; leave once neither is still pending
      WR_REQ: begin
        aw_nx = AWVALID && !AWREADY;
        w_nx = WVALID && !WREADY;
        if (!aw_nx && !w_nx) begin
          b_nx = 1'b1;
          state_nx = WR_RESP;
        end
      end
      WR_RESP: if (BVALID) begin
        b_nx = 1'b0;
        rv_nx = 1'b1;
        err_nx = resp_is_err(BRESP);
        state_nx = IDLE;
      end
      RD_REQ: if (ARREADY) begin
        ar_nx = 1'b0;
        r_nx = 1'b1;
        state_nx = RD_RESP;
      end
      RD_RESP: if (RVALID) begin
        rdata_nx = RDATA;
        err_nx = resp_is_err(RRESP);
        rv_nx = 1'b1;
        r_nx = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      AWVALID <= 1'b0;
      WVALID <= 1'b0;
      BREADY <= 1'b0;
      ARVALID <= 1'b0;
      RREADY <= 1'b0;
      AWADDR <= '0;
      ARADDR <= '0;
      WDATA <= '0;
      WSTRB <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      AWVALID <= aw_nx;
      WVALID <= w_nx;
      BREADY <= b_nx;
      ARVALID <= ar_nx;
      RREADY <= r_nx;
      AWADDR <= awaddr_nx;
      ARADDR <= araddr_nx;
      WDATA <= wdata_nx;
      WSTRB <= wstrb_nx;
      resp_valid <= rv_nx;
      resp_rdata <= rdata_nx;
      resp_err <= err_nx;
    end
  end
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-lite initiator. Converts a simple request/response port from the core's load/store path into AXI4-lite transactions.
- Drives the peripheral register slaves (UART, timers, GPIO) across the AXI4-lite fabric.
- Exactly one transaction, read or write, is in flight at any time.

Parameters:
- ADDR_W, 32, address width. Equals `AXI_ADDR_WIDTH.
- DATA_W, 32, data width. Equals `AXI_DATA_WIDTH.
- STRB_W, DATA_W/8, byte-strobe width. Equals `AXI_STRB_WIDTH.

Ports:
- ACLK  in  1  clock. Single clock domain.
- ARESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  STRB_W  write byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data, valid with resp_valid on reads.
- resp_err  out  1  BRESP/RRESP was SLVERR or DECERR.
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_W, AWPROT out 3.
- WVALID out 1, WREADY in 1, WDATA out DATA_W, WSTRB out STRB_W.
- BVALID in 1, BREADY out 1, BRESP in 2.
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_W, ARPROT out 3.
- RVALID in 1, RREADY out 1, RDATA in DATA_W, RRESP in 2.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state = IDLE.
  - All VALID/READY outputs 0.
  - AWADDR, ARADDR, WDATA, WSTRB, resp_rdata = 0; resp_valid = 0; resp_err = 0.
  - req_ready = 1 after reset.
- Reset mid-transaction: abandons the transaction immediately. No resp_valid is produced. The fabric is reset by the same ARESETn.
- AWPROT and ARPROT are tied to 3'b000.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- req_ready = (state == IDLE). Combinational from the state register only.
- IDLE, on accept:
  - Register req_addr into AWADDR or ARADDR, and req_wdata/req_strb into WDATA/WSTRB.
  - Write: set AWVALID = 1 and WVALID = 1, go to WR_REQ.
  - Read: set ARVALID = 1, go to RD_REQ.
  - VALIDs are visible in the cycle after acceptance.
- WR_REQ:
  - AWVALID drops the cycle after the AW handshake; WVALID drops the cycle after the W handshake. The two are independent.
  - Go to WR_RESP once both handshakes are done, including when both occur in the same cycle. BREADY = 1 on entry.
- WR_RESP:
  - On BVALID && BREADY: BREADY -> 0, pulse resp_valid, set resp_err = BRESP[1], go to IDLE.
- RD_REQ:
  - On ARREADY: ARVALID -> 0, RREADY -> 1, go to RD_RESP.
- RD_RESP:
  - On RVALID && RREADY: capture RDATA into resp_rdata (captured even on error), resp_err = RRESP[1], pulse resp_valid, RREADY -> 0, go to IDLE.
- AXI compliance:
  - VALID never depends combinationally on READY.
  - Once asserted, VALID is held until its handshake.
  - AWADDR, WDATA, WSTRB, ARADDR stay stable while the corresponding VALID is high.
- Timing:
  - resp_valid is a registered single-cycle pulse and is high in the first IDLE cycle.
  - A new request may be accepted in that same cycle.
  - The response side has no backpressure.
- Minimum latencies, accept cycle = 0:
  - Write with all slave READYs high: VALIDs at cycle 1, BREADY at cycle 2; if BVALID at cycle 2, resp_valid at cycle 3.
  - Read with ARREADY at 1 and RVALID at 2: resp_valid at cycle 3.
- Unrequested BVALID or RVALID in any other state is ignored, since BREADY/RREADY are low.
- resp_rdata holds its value until the next read completes.
- resp_err holds its value until the next completion.
- No timeouts: a slave that never responds stalls the master.

Decomposition:
- Shared package `axi_defines`:
  - `AXI_ADDR_WIDTH, `AXI_DATA_WIDTH, `AXI_STRB_WIDTH.
  - Response codes `AXI_RESP_OKAY 2'b00, `AXI_RESP_EXOKAY 2'b01, `AXI_RESP_SLVERR 2'b10, `AXI_RESP_DECERR 2'b11.
- State encoding is local to the module.
- No sub-module is natural; single flat module of roughly 200 lines.

Test Plan:
- Write 0x8 = 0x0000_00A5, strb 4'h1, slave AW/W/B ready immediately.
  - Expect AWVALID/WVALID at cycle 1, resp_valid at cycle 3, resp_err = 0.
  - Expect the UART config1 register to read back 0xA5.
- Write with AWREADY at cycle 1 and WREADY delayed to cycle 4.
  - Expect AWVALID 0 from cycle 2, WVALID held with WDATA stable through cycle 4, BREADY from cycle 5.
  - Expect exactly one resp_valid.
- Read 0x10 with ARREADY delayed 2 cycles and RVALID 3 cycles after that, RDATA = 0x0000_0003, RRESP = OKAY.
  - Expect resp_rdata = 0x3, resp_err = 0, a single resp_valid pulse, ARADDR stable throughout.
- Read returning RRESP = DECERR with RDATA = 0xDEAD_BEEF.
  - Expect resp_err = 1 and resp_rdata = 0xDEAD_BEEF.
  - A following OKAY write clears resp_err to 0.
- Back-to-back: req_valid held for write, then read, then write.
  - Each request is accepted in the resp_valid cycle of the previous one.
  - Never two VALIDs from different transactions at once; three resp_valid pulses in order.
- Assert ARESETn low while in WR_REQ with WVALID pending.
  - All VALID/READY outputs are 0 asynchronously and no resp_valid is produced.
  - After release, req_ready = 1 and a new read completes normally.
